// File: rtl/alu_flag_stage.sv
// alu_flag_stage: 64-bit execute stage that feeds the control unit.
// Takes operands RegA/RegB and an opcode, and returns a registered result
// together with the Z/N/C/V flags that the control unit uses for branches.
// Single-cycle ops deliver their result one cycle after accept. MUL is a
// shift-and-add multiply that processes one multiplier bit per cycle.
// The flag register keeps its value between operations.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (ready only while idle)
//   opcode, RegA, RegB  operation and operands (RegB also gives the shift amount)
//   out_valid/out_ready result handshake toward the control unit
//   result              registered result
//   fZ, fN, fC, fV      zero / negative / carry / overflow flags
module alu_flag_stage #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] RegA,
  input  logic [WIDTH-1:0] RegB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             fZ,
  output logic             fN,
  output logic             fC,
  output logic             fV
);

  localparam int CNT_W = SHAMT_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOTA  = 4'd5;
  localparam logic [3:0] OP_SHL   = 4'd6;
  localparam logic [3:0] OP_SHR   = 4'd7;
  localparam logic [3:0] OP_SAR   = 4'd8;
  localparam logic [3:0] OP_CMP   = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_PASSB = 4'd11;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Single-cycle datapath
  logic [WIDTH:0]       add_full, sub_full, shl_full, shr_full, sar_full;
  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH-1:0]     alu_res, flag_src;
  logic                 alu_c, alu_v;
  logic [2*WIDTH-1:0]   acc_step;

  assign shamt    = RegB[SHAMT_W-1:0];
  assign add_full = {1'b0, RegA} + {1'b0, RegB};
  // Carry out of A + ~B + 1 is the "no borrow" flag (A >= B unsigned).
  assign sub_full = {1'b0, RegA} + {1'b0, ~RegB} + {{WIDTH{1'b0}}, 1'b1};
  // Each shift uses one extra bit so that the last bit shifted out ends up
  // in that spare position. A shift by 0 leaves the spare bit at 0.
  assign shl_full = {1'b0, RegA} << shamt;
  assign shr_full = {RegA, 1'b0} >> shamt;
  assign sar_full = $signed({RegA, 1'b0}) >>> shamt;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (opcode)
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_c   = add_full[WIDTH];
        alu_v   = (RegA[WIDTH-1] == RegB[WIDTH-1]) &&
                  (add_full[WIDTH-1] != RegA[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_c   = sub_full[WIDTH];
        alu_v   = (RegA[WIDTH-1] != RegB[WIDTH-1]) &&
                  (sub_full[WIDTH-1] != RegA[WIDTH-1]);
      end
      OP_AND:   alu_res = RegA & RegB;
      OP_OR:    alu_res = RegA | RegB;
      OP_XOR:   alu_res = RegA ^ RegB;
      OP_NOTA:  alu_res = ~RegA;
      OP_PASSB: alu_res = RegB;
      OP_SHL: begin
        alu_res = shl_full[WIDTH-1:0];
        alu_c   = shl_full[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_full[WIDTH:1];
        alu_c   = shr_full[0];
      end
      OP_SAR: begin
        alu_res = sar_full[WIDTH:1];
        alu_c   = sar_full[0];
      end
      default: ;  // reserved and MUL: zero here; MUL finishes in S_MUL
    endcase
  end

  // CMP computes its flags from the difference but leaves result unchanged.
  assign flag_src = alu_res;
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    v_d      = v_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (opcode == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, RegA};
            mplier_d = RegB;
            acc_d    = '0;
            cnt_d    = CNT_W'(WIDTH);
            state_d  = S_MUL;
          end else begin
            result_d = (opcode == OP_CMP) ? result_q : alu_res;
            z_d      = (flag_src == '0);
            n_d      = flag_src[WIDTH-1];
            c_d      = alu_c;
            v_d      = alu_v;
            state_d  = S_DONE;
          end
        end
      end
      S_MUL: begin
        // The multiplicand is shifted left each cycle, so adding it here
        // is the same as adding A << (WIDTH - count).
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          result_d = acc_step[WIDTH-1:0];
          z_d      = (acc_step[WIDTH-1:0] == '0);
          n_d      = acc_step[WIDTH-1];
          c_d      = 1'b0;
          v_d      = |acc_step[2*WIDTH-1:WIDTH];
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      v_q      <= v_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign fZ        = z_q;
  assign fN        = n_q;
  assign fC        = c_q;
  assign fV        = v_q;

endmodule
